// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg                                                              |
// | Shared state encoding and default PC constants for the fetch stage.    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] c_EXC_PC_DEFAULT   = 32'h0000_4180;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_ctrl                                                             |
// | Fetch-stage sequencer: owns PC_F, drives the imem req/ack port, and    |
// | handles stall, variable latency and flush of an in-flight fetch.       |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_PC   = c_EXC_PC_DEFAULT,
    parameter int          WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] instr_f,
    output logic        valid_f,
    output logic        fetch_err
);

    localparam int             c_CW       = $clog2(WAIT_MAX + 1);
    localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(WAIT_MAX);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WAIT_MAX - 1);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [31:0]     r_pc;
    logic [31:0]     w_pc_next;
    logic [31:0]     r_buf;
    logic [31:0]     w_buf_next;
    logic [31:0]     r_drop_addr;
    logic [31:0]     w_drop_next;
    logic [c_CW-1:0] r_cnt;
    logic            r_err;
    logic [31:0]     w_fetch_addr;
    logic            w_misaligned;
    logic            w_timeout;

    // Misaligned PCs are still fetched, with the low address bits forced to zero.
    assign w_fetch_addr = {r_pc[31:2], 2'b00};
    assign w_misaligned = (r_state == S_REQ) && (r_pc[1:0] != 2'b00);
    assign w_timeout    = imem_req && !imem_ack && !flush && (r_cnt == c_CNT_LAST);

    assign pc_f      = r_pc;
    assign fetch_err = r_err;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_buf_next   = r_buf;
        w_drop_next  = r_drop_addr;
        imem_req     = 1'b0;
        imem_addr    = w_fetch_addr;
        instr_f      = imem_rdata;
        valid_f      = 1'b0;

        case (r_state)
            S_REQ: begin
                imem_req = 1'b1;
                if (flush) begin
                    w_pc_next = EXC_PC;
                    if (!imem_ack) begin
                        w_drop_next  = w_fetch_addr;
                        w_state_next = S_DROP;
                    end
                end else if (imem_ack) begin
                    valid_f = 1'b1;
                    if (stall) begin
                        w_buf_next   = imem_rdata;
                        w_state_next = S_HOLD;
                    end else begin
                        w_pc_next = npc;
                    end
                end
            end
            S_HOLD: begin
                instr_f = r_buf;
                if (flush) begin
                    w_pc_next    = EXC_PC;
                    w_state_next = S_REQ;
                end else begin
                    valid_f = 1'b1;
                    if (!stall) begin
                        w_pc_next    = npc;
                        w_state_next = S_REQ;
                    end
                end
            end
            S_DROP: begin
                // The stale request keeps its address until memory answers it.
                imem_req  = 1'b1;
                imem_addr = r_drop_addr;
                if (flush) begin
                    w_pc_next = EXC_PC;
                end
                if (imem_ack) begin
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase

        if (reset) begin
            imem_req = 1'b0;
            valid_f  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_buf       <= 32'd0;
            r_drop_addr <= 32'd0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_buf       <= w_buf_next;
            r_drop_addr <= w_drop_next;

            // Waiting on a dropped fetch also counts toward the ack timeout.
            if (flush || (imem_req && imem_ack)) begin
                r_cnt <= '0;
            end else if (imem_req && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_timeout || w_misaligned) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_ctrl                                                          |
// | Directed scoreboard bench for fetch_ctrl with a simple memory model.   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_f;
    logic        valid_f;
    logic        fetch_err;

    logic        br_en;
    logic [31:0] br_tgt;

    int          vectors;
    int          miscompares;
    logic [31:0] sb_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0013_0000;
    endfunction

    assign npc        = br_en ? br_tgt : pc_f + 32'd4;
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hBAD0_BAD0;

    fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_f       (pc_f),
        .instr_f    (instr_f),
        .valid_f    (valid_f),
        .fetch_err  (fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance past posedge.
    task automatic cyc(input logic a, input logic s, input logic f,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_instr);
        imem_ack = a;
        stall    = s;
        flush    = f;
        if (e_valid) sb_q.push_back(e_instr);
        @(negedge clk);
        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        if (e_req) chk("imem_addr", imem_addr, e_addr);
        chk("valid_f", {31'd0, valid_f}, {31'd0, e_valid});
        if (valid_f) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                chk("instr_f", instr_f, sb_q.pop_front());
            end
        end
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        br_en       = 1'b0;
        br_tgt      = 32'd0;

        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, valid_f}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_pc", pc_f, 32'h0000_3000);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        reset = 1'b0;

        // Zero-wait streaming
        cyc(1, 0, 0, 1, 32'h3000, 1, mem_word(32'h3000));
        cyc(1, 0, 0, 1, 32'h3004, 1, mem_word(32'h3004));
        cyc(1, 0, 0, 1, 32'h3008, 1, mem_word(32'h3008));

        // Three-cycle ack latency at 0x300C
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 32'h300C, 0, 32'd0);
        cyc(1, 0, 0, 1, 32'h300C, 1, mem_word(32'h300C));
        chk("pc_after_wait", pc_f, 32'h3010);

        // Stall for two cycles on the accept of 0x3010
        cyc(1, 1, 0, 1, 32'h3010, 1, mem_word(32'h3010));
        chk("pc_hold1", pc_f, 32'h3010);
        cyc(0, 1, 0, 0, 32'h0, 1, mem_word(32'h3010));
        chk("pc_hold2", pc_f, 32'h3010);
        cyc(0, 0, 0, 0, 32'h0, 1, mem_word(32'h3010));
        chk("pc_release", pc_f, 32'h3014);

        // Flush with fetch at 0x3014 outstanding
        cyc(0, 0, 1, 1, 32'h3014, 0, 32'd0);
        chk("pc_flush", pc_f, 32'h4180);
        cyc(0, 0, 0, 1, 32'h3014, 0, 32'd0);
        cyc(1, 0, 0, 1, 32'h3014, 0, 32'd0);

        // Taken branch presented on the accept cycle of 0x4180
        br_en  = 1'b1;
        br_tgt = 32'h0000_3100;
        cyc(1, 0, 0, 1, 32'h4180, 1, mem_word(32'h4180));
        br_en  = 1'b0;
        cyc(1, 0, 0, 1, 32'h3100, 1, mem_word(32'h3100));

        // Flush coinciding with an ack discards the data
        cyc(1, 0, 1, 1, 32'h3104, 0, 32'd0);
        chk("pc_flush_ack", pc_f, 32'h4180);

        // Ack timeout: error appears after WAIT_MAX silent cycles and sticks
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 32'h4180, 0, 32'd0);
            chk("err_timeout", {31'd0, fetch_err}, (i == 7) ? 32'd1 : 32'd0);
        end
        cyc(1, 0, 0, 1, 32'h4180, 1, mem_word(32'h4180));
        chk("err_sticky", {31'd0, fetch_err}, 32'd1);

        // Reset clears the error; a misaligned target sets it again
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("err_cleared", {31'd0, fetch_err}, 32'd0);
        chk("pc_rereset", pc_f, 32'h0000_3000);
        br_en  = 1'b1;
        br_tgt = 32'h0000_3202;
        cyc(1, 0, 0, 1, 32'h3000, 1, mem_word(32'h3000));
        br_en  = 1'b0;
        chk("err_pre_misalign", {31'd0, fetch_err}, 32'd0);
        cyc(1, 0, 0, 1, 32'h3200, 1, mem_word(32'h3200));
        chk("err_misalign", {31'd0, fetch_err}, 32'd1);
        chk("pc_misalign_next", pc_f, 32'h3206);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
